// File: rtl/mp_ram_pkg.sv
// Shared types and constants for the multi-port data memory and its arbiter.
package mp_ram_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [31:0] FLAG_ADDR_DEF   = 32'h0000_0FF0;
    localparam logic [31:0] RESULT_ADDR_DEF = 32'h0000_0FF4;

    typedef struct packed {
        logic [31:0]       addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Where the response word comes from in the cycle after the grant.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_MEM,
        SRC_REG
    } rsrc_e;

    function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mp_ram_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins, pointer
// then moves just past the winner. Grants are suppressed while reset is high.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int c;
        c         = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr_q) + i) % N;
            if (!gnt_vld_o && req_i[c] && !rst_i) begin
                gnt_vld_o = 1'b1;
                gnt_o[c]  = 1'b1;
                gnt_idx_o = PTR_W'(c);
            end
        end
        ptr_d = ptr_q;
        if (gnt_vld_o) ptr_d = PTR_W'((int'(gnt_idx_o) + 1) % N);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mp_ram.sv
// Shared word-addressed memory with N round-robin arbitrated ports, byte enables,
// out-of-range error responses and flag/result mailbox registers.
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int          N_PORTS     = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] FLAG_ADDR   = FLAG_ADDR_DEF,
    parameter logic [31:0] RESULT_ADDR = RESULT_ADDR_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_PORTS-1:0]        port_req_i,
    output logic [N_PORTS-1:0]        port_gnt_o,
    output logic [N_PORTS-1:0]        port_rvalid_o,
    input  logic [N_PORTS*32-1:0]     port_addr_i,
    input  logic [N_PORTS-1:0]        port_we_i,
    input  logic [N_PORTS*BE_W-1:0]   port_be_i,
    input  logic [N_PORTS*32-1:0]     port_wdata_i,
    output logic [N_PORTS*32-1:0]     port_rdata_o,
    output logic [N_PORTS-1:0]        port_err_o,
    output logic [31:0]               mem_flag_o,
    output logic [31:0]               mem_result_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_vld;

    rr_arbiter #(
        .N     (N_PORTS),
        .PTR_W (PTR_W)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (port_req_i),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign port_gnt_o = gnt;

    mem_req_t sel;

    always_comb begin
        sel.addr  = port_addr_i[32*int'(gnt_idx) +: 32];
        sel.we    = port_we_i[gnt_idx];
        sel.be    = port_be_i[BE_W*int'(gnt_idx) +: BE_W];
        sel.wdata = port_wdata_i[32*int'(gnt_idx) +: 32];
    end

    logic [DATA_W-1:0] mem_array [DEPTH_WORDS];

    logic [IDX_W-1:0]   idx;
    logic               is_flag, is_res, in_arr, bad, mem_we;
    logic [N_PORTS-1:0] rvalid_q, rvalid_d;
    logic               err_q, err_d;
    rsrc_e              src_q, src_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  flag_q, flag_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0]  resp_rdata;

    always_comb begin
        idx         = sel.addr[IDX_W+1:2];
        is_flag     = (sel.addr[31:2] == FLAG_ADDR[31:2]);
        is_res      = (sel.addr[31:2] == RESULT_ADDR[31:2]);
        in_arr      = ((sel.addr >> (IDX_W + 2)) == 32'd0);
        bad         = !in_arr && !is_flag && !is_res;
        mem_we      = gnt_vld && sel.we && in_arr;
        mem_rdata_d = mem_array[idx];

        rvalid_d = gnt;
        err_d    = gnt_vld && bad;
        src_d    = SRC_ZERO;
        rdata_d  = '0;
        flag_d   = flag_q;
        result_d = result_q;

        // Writes answer with zero data; reads pick mailbox or array word.
        if (gnt_vld && sel.we) begin
            if (is_flag) flag_d   = apply_be(flag_q, sel.wdata, sel.be);
            if (is_res)  result_d = apply_be(result_q, sel.wdata, sel.be);
        end else if (gnt_vld && !bad) begin
            if (is_flag) begin
                src_d   = SRC_REG;
                rdata_d = flag_q;
            end else if (is_res) begin
                src_d   = SRC_REG;
                rdata_d = result_q;
            end else begin
                src_d = SRC_MEM;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            err_q    <= 1'b0;
            src_q    <= SRC_ZERO;
            rdata_q  <= '0;
            flag_q   <= '0;
            result_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            src_q    <= src_d;
            rdata_q  <= rdata_d;
            flag_q   <= flag_d;
            result_q <= result_d;
        end
    end

    // Storage is not reset; mem_we is already blocked during reset via the arbiter.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BE_W; b++) begin
            if (mem_we && sel.be[b]) mem_array[idx][8*b +: 8] <= sel.wdata[8*b +: 8];
        end
        mem_rdata_q <= mem_rdata_d;
    end

    always_comb begin
        resp_rdata = rdata_q;
        if (src_q == SRC_MEM) resp_rdata = mem_rdata_q;
    end

    for (genvar k = 0; k < N_PORTS; k++) begin : g_port
        assign port_rvalid_o[k]        = rvalid_q[k];
        assign port_err_o[k]           = rvalid_q[k] & err_q;
        assign port_rdata_o[32*k +: 32] = rvalid_q[k] ? resp_rdata : '0;
    end

    assign mem_flag_o   = flag_q;
    assign mem_result_o = result_q;

endmodule

// File: tb/tb_mp_ram.sv
// Self-checking bench for mp_ram: directed scenarios plus a randomized run
// against a word/byte-level reference model.
module tb_mp_ram;

    localparam int          N    = 3;
    localparam logic [31:0] FLAG = 32'h0000_0FF0;
    localparam logic [31:0] RES  = 32'h0000_0FF4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, gnt, rvalid, we, err;
    logic [N*32-1:0] addr, wdata, rdata;
    logic [N*4-1:0]  be;
    logic [31:0]     flag, result;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_mem [1024];
    logic [3:0]  m_kn  [1024];

    mp_ram #(
        .N_PORTS     (N),
        .DEPTH_WORDS (1024),
        .FLAG_ADDR   (FLAG),
        .RESULT_ADDR (RES)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .port_req_i    (req),
        .port_gnt_o    (gnt),
        .port_rvalid_o (rvalid),
        .port_addr_i   (addr),
        .port_we_i     (we),
        .port_be_i     (be),
        .port_wdata_i  (wdata),
        .port_rdata_o  (rdata),
        .port_err_o    (err),
        .mem_flag_o    (flag),
        .mem_result_o  (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_port(input int k, input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        req[k]           = 1'b1;
        addr[32*k +: 32] = a;
        we[k]            = w;
        be[4*k +: 4]     = b;
        wdata[32*k +: 32] = d;
    endtask

    // Single lone access on port k; returns what was observed, no judgement.
    task automatic access(input int k, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d,
                          output logic [N-1:0] g, output logic [N-1:0] rv,
                          output logic [31:0] rd, output logic e);
        set_port(k, a, w, b, d);
        @(negedge clk);
        g = gnt;
        tick();
        req[k] = 1'b0;
        rv = rvalid;
        rd = rdata[32*k +: 32];
        e  = err[k];
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] kn);
        return {{8{kn[3]}}, {8{kn[2]}}, {8{kn[1]}}, {8{kn[0]}}};
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            4:          return FLAG;
            5:          return RES;
            6:          return $urandom() | 32'h0000_1000;
            default:    return 32'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic test_reset();
        for (int k = 0; k < N; k++) set_port(k, 32'h10 * k, 1'b1, 4'hF, 32'hFFFF_FFFF);
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rst_gnt: got %b expected 000", gnt); end
        n_cmp++; if (rvalid !== '0) begin n_bad++; $display("FAIL rst_rvalid: got %b expected 000", rvalid); end
        n_cmp++; if (err !== '0 || rdata !== '0) begin n_bad++; $display("FAIL rst_resp: got err %b rdata %h expected 0", err, rdata); end
        n_cmp++; if (flag !== 32'h0 || result !== 32'h0) begin n_bad++; $display("FAIL rst_mbox: got %h/%h expected 0/0", flag, result); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_single();
        logic [N-1:0] g, rv;
        logic [31:0]  rd;
        logic         e;
        access(0, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, g, rv, rd, e);
        n_cmp++; if (g !== 3'b001) begin n_bad++; $display("FAIL single_wr_gnt: got %b expected 001", g); end
        n_cmp++; if (rv !== 3'b001 || rd !== 32'h0 || e !== 1'b0) begin n_bad++; $display("FAIL single_wr_resp: got rv %b rd %h err %b expected 001 0 0", rv, rd, e); end
        access(0, 32'h10, 1'b0, 4'h0, 32'h0, g, rv, rd, e);
        n_cmp++; if (g !== 3'b001) begin n_bad++; $display("FAIL single_rd_gnt: got %b expected 001", g); end
        n_cmp++; if (rv !== 3'b001 || rd !== 32'hDEAD_BEEF || e !== 1'b0) begin n_bad++; $display("FAIL single_rd_resp: got rv %b rd %h err %b expected 001 deadbeef 0", rv, rd, e); end
    endtask

    task automatic test_byte_en();
        logic [N-1:0] g, rv;
        logic [31:0]  rd;
        logic         e;
        access(1, 32'h20, 1'b1, 4'hF, 32'h1122_3344, g, rv, rd, e);
        access(1, 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD, g, rv, rd, e);
        access(1, 32'h20, 1'b1, 4'b0000, 32'hFFFF_FFFF, g, rv, rd, e);
        n_cmp++; if (rv !== 3'b010 || rd !== 32'h0 || e !== 1'b0) begin n_bad++; $display("FAIL be0_resp: got rv %b rd %h err %b expected 010 0 0", rv, rd, e); end
        access(1, 32'h22, 1'b0, 4'h0, 32'h0, g, rv, rd, e);
        n_cmp++; if (g !== 3'b010) begin n_bad++; $display("FAIL be_rd_gnt: got %b expected 010", g); end
        n_cmp++; if (rd !== 32'h11BB_33DD) begin n_bad++; $display("FAIL be_rd_data: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_out_of_range();
        logic [N-1:0] g, rv;
        logic [31:0]  rd;
        logic         e;
        access(2, 32'h0, 1'b1, 4'hF, 32'hCAFE_F00D, g, rv, rd, e);
        access(2, 32'h1000, 1'b1, 4'hF, 32'hFFFF_FFFF, g, rv, rd, e);
        n_cmp++; if (rv !== 3'b100 || e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL oor_wr: got rv %b err %b rd %h expected 100 1 0", rv, e, rd); end
        access(2, 32'h1000, 1'b0, 4'hF, 32'h0, g, rv, rd, e);
        n_cmp++; if (g !== 3'b100 || rv !== 3'b100 || e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd: got g %b rv %b err %b rd %h expected 100 100 1 0", g, rv, e, rd); end
        access(2, 32'h0, 1'b0, 4'hF, 32'h0, g, rv, rd, e);
        n_cmp++; if (e !== 1'b0 || rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL oor_keep: got err %b rd %h expected 0 cafef00d", e, rd); end
    endtask

    task automatic test_mailbox_reset();
        logic [N-1:0] g, rv;
        logic [31:0]  rd;
        logic         e;
        access(0, FLAG, 1'b1, 4'hF, 32'h1, g, rv, rd, e);
        n_cmp++; if (flag !== 32'h1) begin n_bad++; $display("FAIL mbox_flag: got %h expected 1", flag); end
        access(1, RES, 1'b1, 4'hF, 32'd42, g, rv, rd, e);
        n_cmp++; if (result !== 32'd42 || flag !== 32'h1) begin n_bad++; $display("FAIL mbox_result: got %h/%h expected 1/2a", flag, result); end
        access(2, FLAG, 1'b0, 4'h0, 32'h0, g, rv, rd, e);
        n_cmp++; if (rd !== 32'h1 || e !== 1'b0) begin n_bad++; $display("FAIL mbox_rd: got %h err %b expected 1 0", rd, e); end
        access(0, 32'h30, 1'b1, 4'hF, 32'h55AA_55AA, g, rv, rd, e);
        set_port(0, 32'h30, 1'b1, 4'hF, 32'h1234_5678);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rstmid_gnt: got %b expected 000", gnt); end
        tick();
        rst = 1'b0;
        req = '0;
        n_cmp++; if (rvalid !== '0) begin n_bad++; $display("FAIL rstmid_rvalid: got %b expected 000", rvalid); end
        n_cmp++; if (flag !== 32'h0 || result !== 32'h0) begin n_bad++; $display("FAIL rstmid_mbox: got %h/%h expected 0/0", flag, result); end
        access(1, 32'h30, 1'b0, 4'h0, 32'h0, g, rv, rd, e);
        n_cmp++; if (rd !== 32'h55AA_55AA) begin n_bad++; $display("FAIL rstmid_keep: got %h expected 55aa55aa", rd); end
    endtask

    task automatic test_contention();
        logic [N-1:0] eg, prev;
        for (int k = 0; k < N; k++) set_port(k, 32'h40 + 32'(k * 4), 1'b0, 4'hF, 32'h0);
        do_reset();
        prev = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            eg = N'(1 << (i % N));
            n_cmp++; if (gnt !== eg) begin n_bad++; $display("FAIL cont_gnt[%0d]: got %b expected %b", i, gnt, eg); end
            n_cmp++; if (rvalid !== prev) begin n_bad++; $display("FAIL cont_rvalid[%0d]: got %b expected %b", i, rvalid, prev); end
            prev = eg;
            tick();
        end
        req = '0;
        n_cmp++; if (rvalid !== prev) begin n_bad++; $display("FAIL cont_rvalid_last: got %b expected %b", rvalid, prev); end
    endtask

    task automatic test_fairness();
        bit got;
        req = '0;
        do_reset();
        set_port(1, 32'h50, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL fair_solo[%0d]: got %b expected 010", i, gnt); end
            tick();
        end
        set_port(0, 32'h54, 1'b0, 4'hF, 32'h0);
        got = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            if (gnt[0]) begin
                got = 1'b1;
                tick();
                req[0] = 1'b0;
                break;
            end
            tick();
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL fair_p0: got no grant expected grant within 2 cycles"); end
        n_cmp++; if (rvalid !== 3'b001) begin n_bad++; $display("FAIL fair_p0_rvalid: got %b expected 001", rvalid); end
        set_port(0, 32'h54, 1'b0, 4'hF, 32'h0);
        set_port(2, 32'h58, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL fair_ptr: got %b expected 010", gnt); end
        tick();
        req = '0;
    endtask

    task automatic test_random();
        int              ptr = 0, w, c, pk = 0;
        logic [31:0]     mflag = '0, mres = '0, a, exp_d = '0, exp_m = '1;
        logic            exp_v = 1'b0, exp_e = 1'b0, is_f, is_r, in_a;
        logic [9:0]      wi;
        logic [N-1:0]    eg, erv, eerr;
        logic [N*32-1:0] ev, mv;
        for (int i = 0; i < 1024; i++) m_kn[i] = 4'h0;
        req = '0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                req[k]            = ($urandom_range(0, 3) != 0);
                addr[32*k +: 32]  = pick_addr();
                we[k]             = 1'($urandom_range(0, 1));
                be[4*k +: 4]      = 4'($urandom_range(0, 15));
                wdata[32*k +: 32] = $urandom();
            end
            @(negedge clk);
            w = -1;
            for (int i = 0; i < N; i++) begin
                c = (ptr + i) % N;
                if (w < 0 && req[c]) w = c;
            end
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            erv = '0; eerr = '0; ev = '0; mv = '1;
            if (exp_v) begin
                erv[pk] = 1'b1;
                eerr[pk] = exp_e;
                ev[32*pk +: 32] = exp_d;
                mv[32*pk +: 32] = exp_m;
            end
            n_cmp++; if (gnt !== eg) begin n_bad++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", cyc, gnt, eg); end
            n_cmp++; if (rvalid !== erv) begin n_bad++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", cyc, rvalid, erv); end
            n_cmp++; if (err !== eerr) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b expected %b", cyc, err, eerr); end
            n_cmp++; if ((rdata & mv) !== (ev & mv)) begin n_bad++; $display("FAIL rnd_rdata[%0d]: got %h expected %h mask %h", cyc, rdata, ev, mv); end
            n_cmp++; if (flag !== mflag) begin n_bad++; $display("FAIL rnd_flag[%0d]: got %h expected %h", cyc, flag, mflag); end
            n_cmp++; if (result !== mres) begin n_bad++; $display("FAIL rnd_result[%0d]: got %h expected %h", cyc, result, mres); end

            exp_v = (w >= 0);
            if (exp_v) begin
                pk    = w;
                a     = addr[32*w +: 32];
                is_f  = (a[31:2] == FLAG[31:2]);
                is_r  = (a[31:2] == RES[31:2]);
                in_a  = (a < 32'h1000);
                wi    = a[11:2];
                exp_e = !in_a && !is_f && !is_r;
                exp_d = '0;
                exp_m = '1;
                if (we[w]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[4*w + b]) begin
                            if (in_a) begin
                                m_mem[wi][8*b +: 8] = wdata[32*w + 8*b +: 8];
                                m_kn[wi][b] = 1'b1;
                            end
                            if (is_f) mflag[8*b +: 8] = wdata[32*w + 8*b +: 8];
                            if (is_r) mres[8*b +: 8]  = wdata[32*w + 8*b +: 8];
                        end
                    end
                end else if (!exp_e) begin
                    if (is_f)      exp_d = mflag;
                    else if (is_r) exp_d = mres;
                    else begin
                        exp_d = m_mem[wi];
                        exp_m = bmask(m_kn[wi]);
                    end
                end
                ptr = (w + 1) % N;
            end
            tick();
        end
        req = '0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        addr  = '0;
        we    = '0;
        be    = '0;
        wdata = '0;
        tick();
        test_reset();
        test_single();
        test_byte_en();
        test_out_of_range();
        test_mailbox_reset();
        test_contention();
        test_fairness();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mp_ram.md
Name: mp_ram

Overview:
- Shared word-addressed data memory with N_PORTS independent req/gnt/rvalid ports, arbitrated round-robin. Successor to the single-port sp_ram.
- Sits between several cores (lockstep/redundant cluster) and one storage array.
- Adds byte enables, error response, parametrised depth and port count, and registered flag/result mailboxes for testbench observation.

Parameters:
- N_PORTS, 2, number of requester ports (1..8)
- DEPTH_WORDS, 1024, 32-bit words of storage (power of two)
- FLAG_ADDR, 32'h0000_0FF0, byte address of the flag mailbox word
- RESULT_ADDR, 32'h0000_0FF4, byte address of the result mailbox word

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- port_req_i  in  N_PORTS  request per port
- port_gnt_o  out  N_PORTS  grant per port (one-hot or zero)
- port_rvalid_o  out  N_PORTS  response valid per port
- port_addr_i  in  N_PORTS*32  byte address, port k at bits [32k+31:32k]
- port_we_i  in  N_PORTS  1 = write
- port_be_i  in  N_PORTS*4  byte enables
- port_wdata_i  in  N_PORTS*32  write data
- port_rdata_o  out  N_PORTS*32  read data, valid with rvalid
- port_err_o  out  N_PORTS  error flag, valid with rvalid
- mem_flag_o  out  32  last value written to FLAG_ADDR
- mem_result_o  out  32  last value written to RESULT_ADDR

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all gnt/rvalid/err = 0, all rdata = 0, mem_flag_o = 0, mem_result_o = 0, round-robin pointer = 0. Array contents are not reset.
- Grant:
  - Combinational, same cycle as req. At most one gnt per cycle.
  - Winner is the first requesting port found scanning ptr, ptr+1, ... mod N_PORTS.
  - The winner's address, we, be and wdata are sampled at the clock edge where gnt=1.
- Pointer update: after a grant to port k, ptr <= (k+1) mod N_PORTS. With no request, ptr holds.
- A requester holds req and its signals until gnt. Dropping req before gnt is legal: nothing is performed.
- Response latency:
  - port_rvalid_o[k] = 1 exactly one cycle after gnt[k], for reads and writes alike, for one cycle.
  - A port may be granted again in its rvalid cycle, giving back-to-back throughput of 1 access/cycle total.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]. addr[1:0] are ignored.
  - If addr >= DEPTH_WORDS*4 and is neither mailbox: granted normally; rvalid with err=1, rdata=0; no state changes.
- Write (we=1):
  - Bytes with be[i]=1 update; other bytes keep their old value.
  - rdata in the response cycle = 0, err = 0.
  - be=4'b0000 is a legal no-op write.
- Read (we=0): rdata = full word stored before this cycle's write. No write is concurrent because the array is single-ported. be is ignored.
- Mailboxes:
  - A write to FLAG_ADDR or RESULT_ADDR applies the byte-enabled update to the mailbox register, which drives the output the cycle after the grant edge.
  - Mailbox addresses may lie inside or outside the array. If inside, the array word is also written.
  - Reads of a mailbox address return the mailbox register.
- Response outputs: port_rdata_o/port_err_o for non-responding ports = 0.
- Reset mid-operation: a grant issued in the cycle reset is asserted is discarded; no write and no rvalid follow. Mailboxes return to 0.
- N_PORTS=1 degenerates to sp_ram timing plus be/err.

Decomposition:
- Package mp_ram_pkg: DATA_W=32, BE_W=4, the FLAG/RESULT default constants, and a request struct {addr, we, be, wdata}.
- Sub-module rr_arbiter (param N): req vector in, one-hot gnt out, registered pointer with the update rule above. Reused for later cluster interconnect.

Test Plan:
- Single port, write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> each gnt same cycle; rvalid next cycle; read rdata=32'hDEADBEEF, err=0.
- Byte enable: word 0x20 = 32'h11223344, write 32'hAABBCCDD with be=4'b0101, read -> 32'h11BB33DD.
- Contention, N_PORTS=3, all req held high from reset for 6 cycles -> gnt order 0,1,2,0,1,2; one gnt per cycle; each rvalid one cycle after its gnt.
- Fairness: port 1 requests continuously, port 0 requests once at cycle 3 -> port 0 granted within 2 cycles; ptr afterwards = 1.
- Out of range, DEPTH_WORDS=1024, read 0x0000_1000 -> rvalid with err=1, rdata=0; a prior word write is unchanged.
- Mailbox and reset: write 32'h1 to FLAG_ADDR and 32'd42 to RESULT_ADDR -> mem_flag_o=1, mem_result_o=42 the next cycle. Assert rst_i during a granted write to 0x30 -> no rvalid; mailboxes=0; a later read of 0x30 shows the old value.
